// File: rtl/fsm_calibration_multi_if.sv
// ---------------------------------------------------------------------------
// fsm_calibration_multi_if
// Bundles the control, configuration and status signals of the multi-frame
// calibration sequencer so the sequencer and its driver share one port.
//
// Signals (direction given from the sequencer's point of view):
//   start           in   begin a calibration run (honoured only when idle)
//   abort           in   cancel the current run
//   fg_opto         in   frame-grabber opto pulse, rising edge = frame start
//   detector_ready  in   per-channel detector ready level
//   ch_enable       in   channel mask, latched at start
//   fg_open_delay   in   cycles from opto edge to ready check, latched at start
//   trigger_len     in   trigger high time in cycles (0 behaves as 1)
//   ready_timeout   in   max cycles waiting for ready (0 = wait forever)
//   repeat_count    in   frames per run (0 behaves as 1)
//   output_trigger  out  registered trigger pulses
//   busy            out  high whenever a run is in progress
//   done            out  one-cycle pulse on successful completion
//   timeout_err     out  sticky ready-timeout flag
//   frames_done     out  frames triggered in the current/last run
//   scenario_state  out  current state code, zero-extended to 8 bits
//
// Modports: master drives the requests, slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface fsm_calibration_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int REP_W = 16
);
  logic             start;
  logic             abort;
  logic             fg_opto;
  logic [N_CH-1:0]  detector_ready;
  logic [N_CH-1:0]  ch_enable;
  logic [CNT_W-1:0] fg_open_delay;
  logic [CNT_W-1:0] trigger_len;
  logic [CNT_W-1:0] ready_timeout;
  logic [REP_W-1:0] repeat_count;
  logic [N_CH-1:0]  output_trigger;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [REP_W-1:0] frames_done;
  logic [7:0]       scenario_state;

  modport master (
    output start, abort, fg_opto, detector_ready, ch_enable,
           fg_open_delay, trigger_len, ready_timeout, repeat_count,
    input  output_trigger, busy, done, timeout_err, frames_done, scenario_state
  );

  modport slave (
    input  start, abort, fg_opto, detector_ready, ch_enable,
           fg_open_delay, trigger_len, ready_timeout, repeat_count,
    output output_trigger, busy, done, timeout_err, frames_done, scenario_state
  );
endinterface

// File: rtl/fsm_calibration_multi.sv
// ---------------------------------------------------------------------------
// fsm_calibration_multi
// Multi-channel, multi-frame calibration sequencer. For every frame it waits
// for a frame-grabber opto edge, waits the programmed open delay, waits until
// every enabled detector is ready, then fires a programmable-length trigger on
// the enabled channels. A run repeats for the programmed number of frames and
// can end early through the ready timeout or abort.
//
// Ports:
//   clock         system clock
//   reset_signal  synchronous reset, active-high (wins over abort and start)
//   bus           fsm_calibration_multi_if.slave -- requests, configuration
//                 and all registered status outputs
//
// Optional feature: define CALIB_OPTO_SYNC_EN to pass fg_opto through a
// 2-flop synchronizer before edge detection (adds 2 cycles of latency).
// Without it fg_opto is assumed synchronous to clock.
// ---------------------------------------------------------------------------
module fsm_calibration_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int REP_W = 16
) (
  input logic                  clock,
  input logic                  reset_signal,
  fsm_calibration_multi_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_OPTO  = 3'd1,
    OPEN_DELAY = 3'd2,
    WAIT_READY = 3'd3,
    TRIGGER    = 3'd4,
    NEXT       = 3'd5,
    DONE       = 3'd6,
    ERROR      = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] frames_q, frames_d;
  logic             timeoutErr_q, timeoutErr_d;
  logic [N_CH-1:0]  mask_q;
  logic [CNT_W-1:0] delay_q, len_q, timeout_q;
  logic [REP_W-1:0] repeat_q;
  logic             fgOpto_q;
  logic [N_CH-1:0]  trig_q;
  logic             busy_q, done_q;
  logic             runAccept;
  logic             optoSrc, optoEdge;
  logic [CNT_W-1:0] delayEff, lenEff;
  logic [REP_W-1:0] repeatEff, framesInc;

`ifdef CALIB_OPTO_SYNC_EN
  logic optoMeta_q, optoSync_q;

  // Two-flop synchronizer for the asynchronous frame-grabber opto line.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      optoMeta_q <= 1'b0;
      optoSync_q <= 1'b0;
    end else begin
      optoMeta_q <= bus.fg_opto;
      optoSync_q <= optoMeta_q;
    end
  end

  assign optoSrc = optoSync_q;
`else
  assign optoSrc = bus.fg_opto;
`endif

  // A zero delay, length or repeat count behaves as one so every frame spends
  // at least one cycle in each phase and every run fires at least one frame.
  assign optoEdge  = optoSrc & ~fgOpto_q;
  assign delayEff  = (delay_q  == '0) ? CNT_W'(1) : delay_q;
  assign lenEff    = (len_q    == '0) ? CNT_W'(1) : len_q;
  assign repeatEff = (repeat_q == '0) ? REP_W'(1) : repeat_q;
  assign framesInc = frames_q + 1'b1;

  // Next-state logic. The shared counter is reused per phase and cleared on
  // every phase entry. Abort overrides every transition and freezes the
  // frame count and error flag.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frames_d     = frames_q;
    timeoutErr_d = timeoutErr_q;
    runAccept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.ch_enable != '0)) begin
          runAccept    = 1'b1;
          frames_d     = '0;
          timeoutErr_d = 1'b0;
          state_d      = WAIT_OPTO;
        end
      end
      WAIT_OPTO: begin
        if (optoEdge) begin
          state_d = OPEN_DELAY;
          cnt_d   = '0;
        end
      end
      OPEN_DELAY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == delayEff - 1'b1) begin
          state_d = WAIT_READY;
          cnt_d   = '0;
        end
      end
      WAIT_READY: begin
        cnt_d = cnt_q + 1'b1;
        if ((bus.detector_ready & mask_q) == mask_q) begin
          state_d = TRIGGER;
          cnt_d   = '0;
        end else if ((timeout_q != '0) && (cnt_q == timeout_q - 1'b1)) begin
          state_d      = ERROR;
          timeoutErr_d = 1'b1;
        end
      end
      TRIGGER: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == lenEff - 1'b1) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        frames_d = framesInc;
        state_d  = (framesInc == repeatEff) ? DONE : WAIT_OPTO;
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      frames_d     = frames_q;
      timeoutErr_d = timeoutErr_q;
    end
  end

  // State, configuration and output registers. Outputs are derived from the
  // next state so trigger and done line up exactly with the state they
  // belong to, and an abort drops the trigger in the same cycle as the state.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frames_q     <= '0;
      timeoutErr_q <= 1'b0;
      mask_q       <= '0;
      delay_q      <= '0;
      len_q        <= '0;
      timeout_q    <= '0;
      repeat_q     <= '0;
      fgOpto_q     <= 1'b0;
      trig_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frames_q     <= frames_d;
      timeoutErr_q <= timeoutErr_d;
      fgOpto_q     <= optoSrc;
      trig_q       <= (state_d == TRIGGER) ? mask_q : '0;
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
      if (runAccept) begin
        mask_q    <= bus.ch_enable;
        delay_q   <= bus.fg_open_delay;
        len_q     <= bus.trigger_len;
        timeout_q <= bus.ready_timeout;
        repeat_q  <= bus.repeat_count;
      end
    end
  end

  assign bus.output_trigger = trig_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.timeout_err    = timeoutErr_q;
  assign bus.frames_done    = frames_q;
  assign bus.scenario_state = {5'b0, state_q};

endmodule
